piso_serial_tx: RTL and testbench

//  Serial frame transmitter: takes a parallel word via valid/ready handshake, shifts it out
//  LSB-first on one line framed by start bit, optional even parity bit and stop bit. Transmit
//  end of the team's serial link; pairs with the serial-in/parallel-out receiver. Global

---
 rtl/piso_serial_tx.sv | 135 +++++++++++++
 tb/tb_piso_serial_tx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/piso_serial_tx.sv
// Serial frame transmitter: parallel word in via valid/ready, shifted out LSB-first
// framed by start bit, optional even parity bit and stop bit.
module piso_serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               parity_q, parity_d;
  logic               tx_q, tx_d;
  logic               done_q, done_d;
  logic               bit_end;

  assign bit_end  = (div_q == DIV_LAST);
  assign in_ready = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign tx_out   = tx_q;
  assign done     = done_q;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    tx_d     = tx_q;
    // done is a strict one-cycle pulse, cleared on every edge regardless of en
    done_d   = 1'b0;
    if (en) begin
      if (state_q != S_IDLE) begin
        div_d = bit_end ? '0 : div_q + 1'b1;
      end
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            shift_d  = in_data;
            parity_d = ^in_data;
            state_d  = S_START;
            tx_d     = 1'b0;
            div_d    = '0;
          end
        end
        S_START: begin
          if (bit_end) begin
            state_d = S_DATA;
            bit_d   = '0;
            tx_d    = shift_q[0];
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_q == BIT_LAST) begin
              if (PARITY_EN != 0) begin
                state_d = S_PARITY;
                tx_d    = parity_q;
              end else begin
                state_d = S_STOP;
                tx_d    = 1'b1;
              end
            end else begin
              shift_d = shift_q >> 1;
              tx_d    = shift_d[0];
              bit_d   = bit_q + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_piso_serial_tx.sv
// Bench for piso_serial_tx: directed and random frames compared against a
// bit-list reference model built from the frame format.
module tb_piso_serial_tx;

  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       reset;
  logic       en, in_valid, in_ready, tx_out, busy, done;
  logic [7:0] in_data;
  logic       en2, in_valid2, in_ready2, tx_out2, busy2, done2;
  logic [7:0] in_data2;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  bit exp_q[$];

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  piso_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .tx_out(tx_out), .busy(busy), .done(done)
  );

  piso_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut2 (
    .clk(clk), .reset(reset), .en(en2), .in_valid(in_valid2), .in_data(in_data2),
    .in_ready(in_ready2), .tx_out(tx_out2), .busy(busy2), .done(done2)
  );

  task automatic check1(input string tag, input logic obs, input logic exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Expected line value for every enabled cycle after the accept edge.
  function automatic void make_ref(input logic [7:0] d, input int cpb, input bit par);
    bit bits[$];
    int ones = 0;
    exp_q.delete();
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (par) bits.push_back((ones % 2) == 1);
    bits.push_back(1'b1);
    foreach (bits[i]) repeat (cpb) exp_q.push_back(bits[i]);
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Entered and left on a negedge; leaves at the done cycle with in_valid = keep_valid.
  task automatic send1(input logic [7:0] d, input int gap_at, input int gap_len,
                       input bit keep_valid, input logic [7:0] next_d);
    make_ref(d, 4, 1'b1);
    in_valid = 1'b1;
    in_data  = d;
    check1("ready_before_accept", in_ready, 1'b1);
    step();
    for (int k = 0; k < exp_q.size(); k++) begin
      check1($sformatf("tx_%02h_k%0d", d, k), tx_out, exp_q[k]);
      check1("busy_mid", busy, 1'b1);
      check1("done_mid", done, 1'b0);
      check1("ready_mid", in_ready, 1'b0);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      if (k == gap_at) begin
        en = 1'b0;
        repeat (gap_len) begin
          step();
          check1($sformatf("tx_frozen_k%0d", k), tx_out, exp_q[k]);
          check1("done_frozen", done, 1'b0);
        end
        en = 1'b1;
      end
      step();
    end
    check1("done_pulse", done, 1'b1);
    check1("tx_after_stop", tx_out, 1'b1);
    check1("busy_after", busy, 1'b0);
    check1("ready_after", in_ready, 1'b1);
    $display("frame 0x%02h gap_at=%0d gap_len=%0d complete", d, gap_at, gap_len);
    in_valid = keep_valid;
    in_data  = next_d;
  endtask

  initial begin
    reset = 1'b0; en = 1'b1; in_valid = 1'b0; in_data = '0;
    en2 = 1'b1; in_valid2 = 1'b0; in_data2 = '0;

    // Reset with clock stopped
    #1 reset = 1'b1;
    #1;
    check1("rst_tx", tx_out, 1'b1);
    check1("rst_ready", in_ready, 1'b1);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_tx2", tx_out2, 1'b1);
    $display("reset with stopped clock checked");
    clk_run = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    step();

    // Plain 0xA5 frame
    send1(8'hA5, -1, 0, 1'b0, 8'h00);
    step();
    check1("done_clears", done, 1'b0);

    // 0xA5 with en low for 3 cycles inside the data bits
    send1(8'hA5, 4 * 3 + 1, 3, 1'b0, 8'h00);
    step();
    check1("done_clears_gap", done, 1'b0);

    // Reset during data bit 3 of 0x3C
    make_ref(8'h3C, 4, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'h3C;
    step();
    in_valid = 1'b0;
    repeat (17) step();
    check1("abort_tx_before", tx_out, exp_q[17]);
    reset = 1'b1;
    #1;
    check1("abort_tx", tx_out, 1'b1);
    check1("abort_ready", in_ready, 1'b1);
    check1("abort_busy", busy, 1'b0);
    check1("abort_done", done, 1'b0);
    $display("reset mid-frame checked");
    @(negedge clk);
    reset = 1'b0;
    repeat (8) begin
      step();
      check1("abort_no_done", done, 1'b0);
      check1("abort_idle_tx", tx_out, 1'b1);
    end
    send1(8'h01, -1, 0, 1'b0, 8'h00);
    step();

    // Back-to-back with in_valid held
    send1(8'h01, -1, 0, 1'b1, 8'hFE);
    send1(8'hFE, -1, 0, 1'b0, 8'h00);
    step();
    check1("done_clears_b2b", done, 1'b0);

    // Random frames with random enable gaps
    for (int r = 0; r < 4; r++) begin
      logic [7:0] rd;
      int ga;
      rd = 8'($urandom);
      ga = (r == 0) ? -1 : int'($urandom_range(0, 43));
      send1(rd, ga, int'($urandom_range(1, 3)), 1'b0, 8'h00);
      step();
      check1("done_clears_rand", done, 1'b0);
    end

    // CLKS_PER_BIT=1, no parity, 0x80; then en dropped while done is high
    make_ref(8'h80, 1, 1'b0);
    in_valid2 = 1'b1;
    in_data2  = 8'h80;
    check1("ready2_before", in_ready2, 1'b1);
    step();
    in_valid2 = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      check1($sformatf("tx2_k%0d", k), tx_out2, exp_q[k]);
      check1("done2_mid", done2, 1'b0);
      check1("busy2_mid", busy2, 1'b1);
      step();
    end
    check1("done2_pulse", done2, 1'b1);
    check1("tx2_after", tx_out2, 1'b1);
    check1("busy2_after", busy2, 1'b0);
    $display("frame 0x80 on no-parity instance complete");
    en2 = 1'b0;
    step();
    check1("done2_clears_en_low", done2, 1'b0);
    check1("tx2_idle_en_low", tx_out2, 1'b1);
    en2 = 1'b1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
